// File: rtl/sysid_pkg.sv
// System-ID slave shared definitions.
// Register offsets, CTRL bit positions and bus widths.
package sysid_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_ID      = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_TS      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_UP_LO   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_UP_HI   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_CONFIG  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 3'd6;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

endpackage

// File: rtl/sysid_regfile_if.sv
// Avalon-MM slave bus bundle for the system-ID block.
// No waitrequest: the slave accepts every cycle.
interface sysid_regfile_if;
  import sysid_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime_counter.sv
// Prescaled 64-bit uptime counter.
// Clear has priority over a tick; enable=0 freezes both counters.
module sysid_uptime_counter #(
  parameter int PRESCALE = 50
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        clear,
  output logic [63:0] count
);

  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  logic [15:0] prescaler;
  logic [63:0] uptime;
  logic        tick;

  assign tick  = (prescaler == PS_MAX);
  assign count = uptime;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      uptime    <= '0;
    end else if (clear) begin
      prescaler <= '0;
      uptime    <= '0;
    end else if (enable) begin
      if (tick) begin
        prescaler <= '0;
        uptime    <= uptime + 64'd1;
      end else begin
        prescaler <= prescaler + 16'd1;
      end
    end
  end

endmodule

// File: rtl/sysid_regfile.sv
// System-ID / uptime register file on Avalon-MM.
// Read data is muxed at the strobe, then delayed READ_LATENCY cycles.
module sysid_regfile
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter logic [7:0]  VERSION      = 8'd2,
  parameter int          READ_LATENCY = 1,
  parameter int          PRESCALE     = 50
) (
  input logic             clock,
  input logic             reset_n,
  sysid_regfile_if.slave  bus
);

  localparam logic [31:0] CFG_WORD =
    {VERSION, 8'(READ_LATENCY), 16'(PRESCALE)};

  logic              enable;
  logic              wr_ctrl;
  logic              clear;
  logic [63:0]       uptime;
  logic [DATA_W-1:0] scratch;
  logic [DATA_W-1:0] snapshot;
  logic [DATA_W-1:0] rdata;

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_W-1:0]       dat_q [READ_LATENCY];

  assign wr_ctrl = bus.write && (bus.address == ADDR_CTRL);
  assign clear   = wr_ctrl && bus.writedata[CTRL_CLR];

  sysid_uptime_counter #(
    .PRESCALE (PRESCALE)
  ) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (enable),
    .clear   (clear),
    .count   (uptime)
  );

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_ID:      rdata = SYSTEM_ID;
      ADDR_TS:      rdata = TIMESTAMP;
      ADDR_UP_LO:   rdata = uptime[31:0];
      ADDR_UP_HI:   rdata = snapshot;
      ADDR_SCRATCH: rdata = scratch;
      ADDR_CONFIG:  rdata = CFG_WORD;
      ADDR_CTRL:    rdata = {31'b0, enable};
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch  <= '0;
      snapshot <= '0;
      enable   <= 1'b1;
    end else begin
      if (bus.write && bus.address == ADDR_SCRATCH)
        scratch <= bus.writedata;
      if (wr_ctrl)
        enable <= bus.writedata[CTRL_EN];
      // Latch the high word with the same value the low word is read from
      if (bus.read && bus.address == ADDR_UP_LO)
        snapshot <= uptime[63:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        dat_q[i] <= '0;
    end else begin
      vld_q[0] <= bus.read;
      if (bus.read)
        dat_q[0] <= rdata;
      // Data only moves with a valid beat so the output holds between reads
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1])
          dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign bus.readdata      = dat_q[READ_LATENCY-1];
  assign bus.readdatavalid = vld_q[READ_LATENCY-1];

endmodule
